// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: carries EX results and control into the memory stage,
// owns the architectural {N,Z,V} flag register and the sticky halt status.
module ex_mem_reg #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          exValid,
    input  logic [DW-1:0] exAluResult,
    input  logic [2:0]    exFlags,
    input  logic          exFlagsWe,
    input  logic [DW-1:0] exStoreData,
    input  logic [RW-1:0] exDstReg,
    input  logic          exRegWrite,
    input  logic          exMemRead,
    input  logic          exMemWrite,
    input  logic          exMemToReg,
    input  logic          exHlt,
    input  logic [DW-1:0] exPcPlus1,
    output logic [2:0]    flagsToEx,
    output logic          memValid,
    output logic [DW-1:0] memAluResult,
    output logic [DW-1:0] memStoreData,
    output logic [RW-1:0] memDstReg,
    output logic          memRegWrite,
    output logic          memMemRead,
    output logic          memMemWrite,
    output logic          memMemToReg,
    output logic [DW-1:0] memPcPlus1,
    output logic          halted
);

    localparam int unsigned FW = 3;

    logic          valid_q,      valid_d;
    logic [DW-1:0] alu_result_q, alu_result_d;
    logic [DW-1:0] store_data_q, store_data_d;
    logic [RW-1:0] dst_reg_q,    dst_reg_d;
    logic          reg_write_q,  reg_write_d;
    logic          mem_read_q,   mem_read_d;
    logic          mem_write_q,  mem_write_d;
    logic          mem_to_reg_q, mem_to_reg_d;
    logic [DW-1:0] pc_plus1_q,   pc_plus1_d;
    logic          halted_q,     halted_d;
    logic [FW-1:0] flags_q,      flags_d;

    logic          take_c;
    logic          flags_bypass_c;
    logic [FW-1:0] flags_next_c;

    // Capture qualifier; a halted pipe only ever emits bubbles.
    assign take_c = exValid & ~stall & ~flush & ~halted_q;

    // Bypass mux: what the flag register becomes if this cycle is not stalled.
    assign flags_bypass_c = exValid & exFlagsWe & ~flush & ~halted_q;
    assign flags_next_c   = flags_bypass_c ? exFlags : flags_q;

    always_comb begin
        valid_d      = valid_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        dst_reg_d    = dst_reg_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        pc_plus1_d   = pc_plus1_q;
        halted_d     = halted_q;
        flags_d      = flags_q;

        if (!stall) begin
            flags_d = flags_next_c;
            if (take_c) begin
                valid_d      = 1'b1;
                alu_result_d = exAluResult;
                store_data_d = exStoreData;
                dst_reg_d    = exDstReg;
                reg_write_d  = exRegWrite;
                mem_read_d   = exMemRead;
                mem_write_d  = exMemWrite;
                mem_to_reg_d = exMemToReg;
                pc_plus1_d   = exPcPlus1;
                halted_d     = halted_q | exHlt;
            end else begin
                // Bubble: side-effecting controls must drop with valid.
                valid_d     = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            dst_reg_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_plus1_q   <= '0;
            halted_q     <= 1'b0;
            flags_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            dst_reg_q    <= dst_reg_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            pc_plus1_q   <= pc_plus1_d;
            halted_q     <= halted_d;
            flags_q      <= flags_d;
        end
    end

    // EX's own op reads the registered flags; its result lands here next edge.
    assign flagsToEx    = flags_q;
    assign memValid     = valid_q;
    assign memAluResult = alu_result_q;
    assign memStoreData = store_data_q;
    assign memDstReg    = dst_reg_q;
    assign memRegWrite  = reg_write_q;
    assign memMemRead   = mem_read_q;
    assign memMemWrite  = mem_write_q;
    assign memMemToReg  = mem_to_reg_q;
    assign memPcPlus1   = pc_plus1_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, pass-through, stall/flush, flags, halt.
module tb_ex_mem_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, exValid, exFlagsWe;
    logic [DW-1:0] exAluResult, exStoreData, exPcPlus1;
    logic [2:0]    exFlags;
    logic [RW-1:0] exDstReg;
    logic          exRegWrite, exMemRead, exMemWrite, exMemToReg, exHlt;
    logic [2:0]    flagsToEx;
    logic          memValid, memRegWrite, memMemRead, memMemWrite, memMemToReg, halted;
    logic [DW-1:0] memAluResult, memStoreData, memPcPlus1;
    logic [RW-1:0] memDstReg;

    int errors = 0;
    int checks = 0;

    ex_mem_reg #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .exValid(exValid), .exAluResult(exAluResult), .exFlags(exFlags),
        .exFlagsWe(exFlagsWe), .exStoreData(exStoreData), .exDstReg(exDstReg),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exMemToReg(exMemToReg), .exHlt(exHlt), .exPcPlus1(exPcPlus1),
        .flagsToEx(flagsToEx), .memValid(memValid), .memAluResult(memAluResult),
        .memStoreData(memStoreData), .memDstReg(memDstReg), .memRegWrite(memRegWrite),
        .memMemRead(memMemRead), .memMemWrite(memMemWrite), .memMemToReg(memMemToReg),
        .memPcPlus1(memPcPlus1), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; exValid = 0; exFlagsWe = 0; exFlags = 3'b000;
        exAluResult = '0; exStoreData = '0; exPcPlus1 = '0; exDstReg = '0;
        exRegWrite = 0; exMemRead = 0; exMemWrite = 0; exMemToReg = 0; exHlt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        checks++; if (memValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", memValid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (flagsToEx !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", flagsToEx); end
        checks++; if (memAluResult !== 16'h0000) begin errors++; $display("FAIL reset_alu: got %h expected 0000", memAluResult); end
        rst_n = 1;
        step();
    endtask

    task automatic test_pass_through();
        idle_inputs();
        exValid = 1; exAluResult = 16'h00A5; exDstReg = 4'd3; exRegWrite = 1; exPcPlus1 = 16'h0011;
        step();
        checks++; if (memValid !== 1'b1) begin errors++; $display("FAIL pt_valid: got %b expected 1", memValid); end
        checks++; if (memAluResult !== 16'h00A5) begin errors++; $display("FAIL pt_alu: got %h expected 00a5", memAluResult); end
        checks++; if (memDstReg !== 4'd3) begin errors++; $display("FAIL pt_dst: got %0d expected 3", memDstReg); end
        checks++; if (memRegWrite !== 1'b1) begin errors++; $display("FAIL pt_regwrite: got %b expected 1", memRegWrite); end
        checks++; if (memPcPlus1 !== 16'h0011) begin errors++; $display("FAIL pt_pc: got %h expected 0011", memPcPlus1); end
        // Back-to-back LW with mem-to-reg
        exAluResult = 16'h0042; exDstReg = 4'd7; exMemRead = 1; exMemToReg = 1;
        step();
        checks++; if (memAluResult !== 16'h0042 || memMemRead !== 1'b1 || memMemToReg !== 1'b1 || memDstReg !== 4'd7)
            begin errors++; $display("FAIL b2b_lw: got alu=%h rd=%b m2r=%b dst=%0d expected 0042 1 1 7", memAluResult, memMemRead, memMemToReg, memDstReg); end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        exValid = 1; exMemWrite = 1; exStoreData = 16'hBEEF; exAluResult = 16'h0020;
        step();
        checks++; if (memStoreData !== 16'hBEEF || memMemWrite !== 1'b1) begin errors++; $display("FAIL sw_load: got data=%h we=%b expected beef 1", memStoreData, memMemWrite); end
        stall = 1; flush = 1; exStoreData = 16'h1111; exMemWrite = 0; exRegWrite = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (memStoreData !== 16'hBEEF || memMemWrite !== 1'b1 || memValid !== 1'b1)
                begin errors++; $display("FAIL stall_hold%0d: got data=%h we=%b v=%b expected beef 1 1", i, memStoreData, memMemWrite, memValid); end
        end
        stall = 0;
        step();
        checks++; if (memValid !== 1'b0 || memMemWrite !== 1'b0 || memRegWrite !== 1'b0)
            begin errors++; $display("FAIL flush_bubble: got v=%b we=%b rw=%b expected 0 0 0", memValid, memMemWrite, memRegWrite); end
    endtask

    task automatic test_flags();
        idle_inputs();
        exValid = 1; exFlagsWe = 1; exFlags = 3'b010; exRegWrite = 1;
        #1;
        checks++; if (flagsToEx !== 3'b000) begin errors++; $display("FAIL flags_pre_edge: got %b expected 000", flagsToEx); end
        step();
        checks++; if (flagsToEx !== 3'b010) begin errors++; $display("FAIL flags_add: got %b expected 010", flagsToEx); end
        exFlagsWe = 0; exFlags = 3'b100; exMemRead = 1;
        step();
        checks++; if (flagsToEx !== 3'b010) begin errors++; $display("FAIL flags_lw: got %b expected 010", flagsToEx); end
        exFlagsWe = 1; exFlags = 3'b001; exMemRead = 0; flush = 1;
        step();
        checks++; if (flagsToEx !== 3'b010) begin errors++; $display("FAIL flags_flushed: got %b expected 010", flagsToEx); end
        flush = 0; stall = 1; exFlags = 3'b111;
        step();
        checks++; if (flagsToEx !== 3'b010) begin errors++; $display("FAIL flags_stalled: got %b expected 010", flagsToEx); end
        stall = 0;
        step();
        checks++; if (flagsToEx !== 3'b111) begin errors++; $display("FAIL flags_after_stall: got %b expected 111", flagsToEx); end
        exFlags = 3'b010;
        step();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        exValid = 1; exAluResult = 16'h1234;
        step();
        checks++; if (memAluResult !== 16'h1234) begin errors++; $display("FAIL mid_load: got %h expected 1234", memAluResult); end
        #2 rst_n = 0;
        #1;
        checks++; if (memValid !== 1'b0 || memAluResult !== 16'h0000 || flagsToEx !== 3'b000)
            begin errors++; $display("FAIL mid_reset: got v=%b alu=%h f=%b expected 0 0000 000", memValid, memAluResult, flagsToEx); end
        idle_inputs();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_halt();
        idle_inputs();
        exValid = 1; exHlt = 1;
        step();
        checks++; if (halted !== 1'b1 || memValid !== 1'b1) begin errors++; $display("FAIL hlt_capture: got h=%b v=%b expected 1 1", halted, memValid); end
        exHlt = 0; exRegWrite = 1; exFlagsWe = 1; exFlags = 3'b101; exAluResult = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (memValid !== 1'b0 || memRegWrite !== 1'b0 || halted !== 1'b1 || flagsToEx !== 3'b000)
                begin errors++; $display("FAIL halted_bubble%0d: got v=%b rw=%b h=%b f=%b expected 0 0 1 000", i, memValid, memRegWrite, halted, flagsToEx); end
        end
        #2 rst_n = 0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hlt_reset: got %b expected 0", halted); end
        rst_n = 1;
        step();
        checks++; if (memValid !== 1'b1 || memAluResult !== 16'h7777 || memRegWrite !== 1'b1)
            begin errors++; $display("FAIL post_hlt_take: got v=%b alu=%h rw=%b expected 1 7777 1", memValid, memAluResult, memRegWrite); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall_flush();
        test_flags();
        test_reset_mid();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
